// File: rtl/tilemap_pkg.sv
// Shared types and built-in level maps for the tile-map renderer.
// Maps are stored as [map][row][col] tile codes; rom_tile() gives safe indexed access.
package tilemap_pkg;

  localparam int DEF_ROWS = 7;
  localparam int DEF_COLS = 10;
  localparam int DEF_MAPS = 2;

  localparam int DEF_MAP_IW = (DEF_MAPS > 1) ? $clog2(DEF_MAPS) : 1;
  localparam int DEF_ROW_IW = (DEF_ROWS > 1) ? $clog2(DEF_ROWS) : 1;
  localparam int DEF_COL_IW = (DEF_COLS > 1) ? $clog2(DEF_COLS) : 1;

  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    REGU = 2'd1,
    BRKB = 2'd2,
    BONU = 2'd3
  } tile_t;

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam tile_t MAP_ROM [DEF_MAPS][DEF_ROWS][DEF_COLS] = '{
    '{
      '{REGU, REGU, REGU, REGU, REGU, REGU, REGU, REGU, REGU, REGU},
      '{REGU, BRKB, BRKB, BRKB, BRKB, BRKB, BRKB, BRKB, BRKB, REGU},
      '{REGU, FREE, BRKB, FREE, BRKB, BRKB, FREE, BRKB, BONU, REGU},
      '{REGU, FREE, FREE, FREE, FREE, FREE, FREE, FREE, FREE, REGU},
      '{REGU, FREE, FREE, FREE, FREE, FREE, FREE, FREE, FREE, REGU},
      '{REGU, FREE, FREE, FREE, FREE, FREE, FREE, FREE, FREE, REGU},
      '{REGU, FREE, FREE, FREE, FREE, FREE, FREE, FREE, FREE, REGU}
    },
    '{
      '{REGU, FREE, FREE, FREE, FREE, FREE, FREE, FREE, FREE, REGU},
      '{FREE, FREE, FREE, FREE, FREE, FREE, FREE, FREE, FREE, FREE},
      '{FREE, FREE, FREE, FREE, FREE, FREE, FREE, FREE, FREE, FREE},
      '{FREE, FREE, FREE, BRKB, FREE, BRKB, FREE, BRKB, FREE, FREE},
      '{FREE, FREE, FREE, FREE, FREE, FREE, FREE, FREE, FREE, FREE},
      '{FREE, FREE, FREE, FREE, FREE, FREE, FREE, FREE, FREE, FREE},
      '{REGU, FREE, FREE, FREE, BONU, FREE, FREE, FREE, FREE, REGU}
    }
  };

  // Anything outside the stored maps reads as FREE, so a larger top-level grid never indexes past the ROM.
  function automatic tile_t rom_tile(input logic [7:0] m, input logic [7:0] r, input logic [7:0] c);
    if (m >= 8'(DEF_MAPS) || r >= 8'(DEF_ROWS) || c >= 8'(DEF_COLS))
      return FREE;
    return MAP_ROM[m[DEF_MAP_IW-1:0]][r[DEF_ROW_IW-1:0]][c[DEF_COL_IW-1:0]];
  endfunction

endpackage

// File: rtl/tilemap_row_popcount.sv
// Counts breakable (BRKB) tiles in one packed row of 2-bit tile codes.
module tilemap_row_popcount
  import tilemap_pkg::*;
#(
  parameter int NUM_OF_COLS = 10,
  parameter int CNT_W = $clog2(NUM_OF_COLS + 1)
) (
  input  logic [2*NUM_OF_COLS-1:0] row_tiles,
  output logic [CNT_W-1:0]         brkb_count
);

  always_comb begin
    brkb_count = '0;
    for (int c = 0; c < NUM_OF_COLS; c++) begin
      if (row_tiles[2*c +: 2] == BRKB)
        brkb_count = brkb_count + 1'b1;
    end
  end

endmodule

// File: rtl/tile_map_renderer.sv
// Runtime-writable tile grid with map loader and 2-stage pixel lookup pipeline.
// Optional feature macro: TILEMAP_REMAIN_CNT_EN (breakable-tile counter driving level_clear).
module tile_map_renderer
  import tilemap_pkg::*;
#(
  parameter int TILE_SHIFT  = 6,
  parameter int NUM_OF_ROWS = 7,
  parameter int NUM_OF_COLS = 10,
  parameter int NUM_OF_MAPS = 2,
  parameter int MAP_W = (NUM_OF_MAPS > 1) ? $clog2(NUM_OF_MAPS) : 1,
  parameter logic [7:0] COLOR_REGU = 8'h5B,
  parameter logic [7:0] COLOR_BRKB = 8'hE0,
  parameter logic [7:0] COLOR_BONU = 8'h1C
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      pixelX,
  input  logic [10:0]      pixelY,
  input  logic [MAP_W-1:0] map_sel,
  input  logic             load_req,
  output logic             load_busy,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [3:0]       wr_row,
  input  logic [3:0]       wr_col,
  input  logic [1:0]       wr_type,
  output logic [10:0]      offsetX,
  output logic [10:0]      offsetY,
  output logic             tile_drawingRequest,
  output logic [1:0]       tile_type,
  output logic [7:0]       RGBout,
  output logic             level_clear
);

  localparam int ROW_W = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS) : 1;
  localparam int COL_W = (NUM_OF_COLS > 1) ? $clog2(NUM_OF_COLS) : 1;
  localparam logic [MAP_W:0] MAP_LIMIT = (MAP_W + 1)'(NUM_OF_MAPS);
  localparam logic [10:0] OFF_MASK = 11'((1 << TILE_SHIFT) - 1);

  state_t                 state;
  logic [ROW_W-1:0]       load_row;
  logic [MAP_W-1:0]       map_idx;
  tile_t                  grid [NUM_OF_ROWS][NUM_OF_COLS];
  logic [2*NUM_OF_COLS-1:0] rom_row;

  logic                   wr_in_range;
  logic [ROW_W-1:0]       wr_r_idx;
  logic [COL_W-1:0]       wr_c_idx;
  tile_t                  wr_old;
  logic                   wr_apply;

  logic [10:0]            px_col;
  logic [10:0]            px_row;
  logic                   px_inside;
  logic                   s1_inside;
  logic [ROW_W-1:0]       s1_row;
  logic [COL_W-1:0]       s1_col;
  logic [10:0]            s1_offX;
  logic [10:0]            s1_offY;
  tile_t                  s2_type;
  logic                   s2_draw;
  logic [7:0]             s2_rgb;

  assign load_busy = (state == ST_LOAD);
  assign wr_ready  = (state == ST_READY) && !load_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_LOAD;
      load_row <= '0;
      map_idx  <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (load_row == ROW_W'(NUM_OF_ROWS - 1)) begin
            state    <= ST_READY;
            load_row <= '0;
          end else begin
            load_row <= load_row + 1'b1;
          end
        end
        ST_READY: begin
          if (load_req) begin
            state    <= ST_LOAD;
            load_row <= '0;
            map_idx  <= ({1'b0, map_sel} >= MAP_LIMIT) ? '0 : map_sel;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  always_comb begin
    rom_row = '0;
    for (int c = 0; c < NUM_OF_COLS; c++)
      rom_row[2*c +: 2] = rom_tile(8'(map_idx), 8'(load_row), 8'(c));
  end

  // Out-of-range coordinates are steered to cell (0,0) so the REGU lookup never indexes past the grid.
  assign wr_in_range = ({1'b0, wr_row} < 5'(NUM_OF_ROWS)) && ({1'b0, wr_col} < 5'(NUM_OF_COLS));
  assign wr_r_idx    = wr_in_range ? wr_row[ROW_W-1:0] : '0;
  assign wr_c_idx    = wr_in_range ? wr_col[COL_W-1:0] : '0;
  assign wr_old      = grid[wr_r_idx][wr_c_idx];
  assign wr_apply    = wr_valid && wr_ready && wr_in_range && (wr_old != REGU);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_OF_ROWS; r++)
        for (int c = 0; c < NUM_OF_COLS; c++)
          grid[r][c] <= FREE;
    end else if (state == ST_LOAD) begin
      for (int c = 0; c < NUM_OF_COLS; c++)
        grid[load_row][c] <= tile_t'(rom_row[2*c +: 2]);
    end else if (wr_apply) begin
      grid[wr_r_idx][wr_c_idx] <= tile_t'(wr_type);
    end
  end

  assign px_col    = pixelX >> TILE_SHIFT;
  assign px_row    = pixelY >> TILE_SHIFT;
  assign px_inside = (px_col < 11'(NUM_OF_COLS)) && (px_row < 11'(NUM_OF_ROWS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_inside <= 1'b0;
      s1_row    <= '0;
      s1_col    <= '0;
      s1_offX   <= '0;
      s1_offY   <= '0;
    end else begin
      s1_inside <= px_inside;
      s1_row    <= px_inside ? px_row[ROW_W-1:0] : '0;
      s1_col    <= px_inside ? px_col[COL_W-1:0] : '0;
      s1_offX   <= pixelX & OFF_MASK;
      s1_offY   <= pixelY & OFF_MASK;
    end
  end

  assign s2_type = s1_inside ? grid[s1_row][s1_col] : FREE;
  assign s2_draw = s1_inside && (s2_type != FREE) && (state == ST_READY);

  always_comb begin
    s2_rgb = TRANSPARENT_ENCODING;
    case (s2_type)
      REGU:    s2_rgb = COLOR_REGU;
      BRKB:    s2_rgb = COLOR_BRKB;
      BONU:    s2_rgb = COLOR_BONU;
      default: s2_rgb = TRANSPARENT_ENCODING;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tile_drawingRequest <= 1'b0;
      tile_type           <= 2'd0;
      RGBout              <= TRANSPARENT_ENCODING;
      offsetX             <= '0;
      offsetY             <= '0;
    end else begin
      tile_drawingRequest <= s2_draw;
      tile_type           <= s2_type;
      RGBout              <= s2_draw ? s2_rgb : TRANSPARENT_ENCODING;
      offsetX             <= s1_offX;
      offsetY             <= s1_offY;
    end
  end

`ifdef TILEMAP_REMAIN_CNT_EN
  localparam int CNT_W = $clog2(NUM_OF_ROWS * NUM_OF_COLS + 1);
  localparam int PC_W  = $clog2(NUM_OF_COLS + 1);

  logic [PC_W-1:0]  row_brkb;
  logic [CNT_W-1:0] brkb_cnt;

  tilemap_row_popcount #(
    .NUM_OF_COLS(NUM_OF_COLS),
    .CNT_W(PC_W)
  ) u_row_popcount (
    .row_tiles(rom_row),
    .brkb_count(row_brkb)
  );

  // Count restarts on every load; writes only move it when BRKB membership of the cell changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brkb_cnt    <= '0;
      level_clear <= 1'b0;
    end else begin
      if (state == ST_LOAD) begin
        brkb_cnt <= brkb_cnt + CNT_W'(row_brkb);
      end else if (load_req) begin
        brkb_cnt <= '0;
      end else if (wr_apply) begin
        if ((wr_old == BRKB) && (wr_type != BRKB))
          brkb_cnt <= brkb_cnt - 1'b1;
        else if ((wr_old != BRKB) && (wr_type == BRKB))
          brkb_cnt <= brkb_cnt + 1'b1;
      end
      level_clear <= (state == ST_READY) && (brkb_cnt == '0);
    end
  end
`else
  assign level_clear = 1'b0;
`endif

endmodule

// File: tb/tb_tile_map_renderer.sv
// Directed self-checking bench for tile_map_renderer: table-driven pixel lookups plus
// hand-written sequences for load timing, write hazards and reset during a load.
`timescale 1ns/1ps
module tb_tile_map_renderer;
  import tilemap_pkg::*;

  typedef struct {
    string       name;
    logic [10:0] x;
    logic [10:0] y;
    logic        draw;
    logic [1:0]  ttype;
    logic [7:0]  rgb;
    logic [10:0] offx;
    logic [10:0] offy;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] pixelX, pixelY;
  logic [0:0]  map_sel;
  logic        load_req, load_busy;
  logic        wr_valid, wr_ready;
  logic [3:0]  wr_row, wr_col;
  logic [1:0]  wr_type;
  logic [10:0] offsetX, offsetY;
  logic        tile_drawingRequest;
  logic [1:0]  tile_type;
  logic [7:0]  RGBout;
  logic        level_clear;

  int checks = 0;
  int failures = 0;

  vec_t map0Vecs [9];
  vec_t map1Vecs [7];

  tile_map_renderer dut (
    .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
    .map_sel(map_sel), .load_req(load_req), .load_busy(load_busy),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col),
    .wr_type(wr_type), .offsetX(offsetX), .offsetY(offsetY),
    .tile_drawingRequest(tile_drawingRequest), .tile_type(tile_type),
    .RGBout(RGBout), .level_clear(level_clear)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Present a pixel at a falling edge and land on the falling edge after its result emerges.
  task automatic applyStimulus(input logic [10:0] x, input logic [10:0] y);
    @(negedge clk);
    pixelX = x;
    pixelY = y;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkVector(input vec_t v);
    applyStimulus(v.x, v.y);
    checkOutput({v.name, " draw"}, tile_drawingRequest, v.draw);
    checkOutput({v.name, " type"}, tile_type, v.ttype);
    checkOutput({v.name, " rgb"},  RGBout, v.rgb);
    checkOutput({v.name, " offx"}, offsetX, v.offx);
    checkOutput({v.name, " offy"}, offsetY, v.offy);
  endtask

  task automatic writeTile(input logic [3:0] r, input logic [3:0] c, input logic [1:0] t, input string name);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_row   = r;
    wr_col   = c;
    wr_type  = t;
    #1 checkOutput({name, " wr_ready"}, wr_ready, 1);
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  initial begin
    map0Vecs[0] = '{name:"m0 wall00",  x:5,   y:5,   draw:1, ttype:1, rgb:8'h5B, offx:5,  offy:5};
    map0Vecs[1] = '{name:"m0 brkb11",  x:70,  y:70,  draw:1, ttype:2, rgb:8'hE0, offx:6,  offy:6};
    map0Vecs[2] = '{name:"m0 free23",  x:200, y:140, draw:0, ttype:0, rgb:8'hFF, offx:8,  offy:12};
    map0Vecs[3] = '{name:"m0 outX",    x:650, y:10,  draw:0, ttype:0, rgb:8'hFF, offx:10, offy:10};
    map0Vecs[4] = '{name:"m0 outY",    x:10,  y:460, draw:0, ttype:0, rgb:8'hFF, offx:10, offy:12};
    map0Vecs[5] = '{name:"m0 bonu28",  x:520, y:140, draw:1, ttype:3, rgb:8'h1C, offx:8,  offy:12};
    map0Vecs[6] = '{name:"m0 corner",  x:639, y:447, draw:1, ttype:1, rgb:8'h5B, offx:63, offy:63};
    map0Vecs[7] = '{name:"m0 free44",  x:300, y:300, draw:0, ttype:0, rgb:8'hFF, offx:44, offy:44};
    map0Vecs[8] = '{name:"m0 brkb22",  x:130, y:130, draw:1, ttype:2, rgb:8'hE0, offx:2,  offy:2};

    map1Vecs[0] = '{name:"m1 wall00",  x:5,   y:5,   draw:1, ttype:1, rgb:8'h5B, offx:5,  offy:5};
    map1Vecs[1] = '{name:"m1 free11",  x:70,  y:70,  draw:0, ttype:0, rgb:8'hFF, offx:6,  offy:6};
    map1Vecs[2] = '{name:"m1 brkb33",  x:200, y:200, draw:1, ttype:2, rgb:8'hE0, offx:8,  offy:8};
    map1Vecs[3] = '{name:"m1 brkb35",  x:320, y:200, draw:1, ttype:2, rgb:8'hE0, offx:0,  offy:8};
    map1Vecs[4] = '{name:"m1 bonu64",  x:260, y:400, draw:1, ttype:3, rgb:8'h1C, offx:4,  offy:16};
    map1Vecs[5] = '{name:"m1 wall09",  x:580, y:10,  draw:1, ttype:1, rgb:8'h5B, offx:4,  offy:10};
    map1Vecs[6] = '{name:"m1 free22",  x:130, y:130, draw:0, ttype:0, rgb:8'hFF, offx:2,  offy:2};

    reset = 1'b1;
    pixelX = 11'd650;
    pixelY = 11'd10;
    map_sel = 1'b0;
    load_req = 1'b0;
    wr_valid = 1'b0;
    wr_row = '0;
    wr_col = '0;
    wr_type = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst load_busy", load_busy, 1);
    checkOutput("rst wr_ready", wr_ready, 0);
    checkOutput("rst draw", tile_drawingRequest, 0);
    checkOutput("rst type", tile_type, 0);
    checkOutput("rst rgb", RGBout, 8'hFF);
    checkOutput("rst offx", offsetX, 0);
    checkOutput("rst offy", offsetY, 0);
    checkOutput("rst level_clear", level_clear, 0);

    reset = 1'b0;
    checkOutput("release load_busy", load_busy, 1);
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("boot load_busy c%0d", i), load_busy, (i < 7));
      checkOutput($sformatf("boot wr_ready c%0d", i), wr_ready, (i == 7));
    end

    // Exactly two cycles from presentation to result.
    pixelX = 11'd5;
    pixelY = 11'd5;
    @(posedge clk);
    @(negedge clk);
    checkOutput("latency c1 rgb", RGBout, 8'hFF);
    @(posedge clk);
    @(negedge clk);
    checkOutput("latency c2 rgb", RGBout, 8'h5B);
    checkOutput("latency c2 draw", tile_drawingRequest, 1);

    for (int i = 0; i < 9; i++)
      checkVector(map0Vecs[i]);

    writeTile(4'd2, 4'd3, BRKB, "w brkb 2,3");
    checkVector('{name:"after brkb 2,3", x:200, y:140, draw:1, ttype:2, rgb:8'hE0, offx:8, offy:12});

    // Write lands on the same edge that stage 2 reads the cell: old value first, new one next.
    @(negedge clk);
    pixelX = 11'd200;
    pixelY = 11'd140;
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_row = 4'd2;
    wr_col = 4'd3;
    wr_type = BONU;
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    checkOutput("same-cycle rgb old", RGBout, 8'hE0);
    checkOutput("same-cycle type old", tile_type, 2);
    @(posedge clk);
    @(negedge clk);
    checkOutput("next-cycle rgb new", RGBout, 8'h1C);
    checkOutput("next-cycle type new", tile_type, 3);

    writeTile(4'd0, 4'd0, FREE, "w free wall");
    checkVector('{name:"wall immutable", x:5, y:5, draw:1, ttype:1, rgb:8'h5B, offx:5, offy:5});
    writeTile(4'd9, 4'd1, FREE, "w row oob");
    checkVector('{name:"oob no effect", x:70, y:70, draw:1, ttype:2, rgb:8'hE0, offx:6, offy:6});
    writeTile(4'd2, 4'd3, REGU, "w regu 2,3");
    checkVector('{name:"regu placed", x:200, y:140, draw:1, ttype:1, rgb:8'h5B, offx:8, offy:12});

    // Reload map 1 mid-frame; a second request during the load must be ignored.
    @(negedge clk);
    pixelX = 11'd5;
    pixelY = 11'd5;
    map_sel = 1'b1;
    load_req = 1'b1;
    #1;
    checkOutput("load_req wr_ready", wr_ready, 0);
    checkOutput("load_req busy", load_busy, 0);
    @(posedge clk);
    @(negedge clk);
    load_req = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("reload draw c%0d", i), tile_drawingRequest, (i == 8));
      checkOutput($sformatf("reload busy c%0d", i), load_busy, (i < 7));
      if (i == 2) begin
        load_req = 1'b1;
        map_sel = 1'b0;
        #1 checkOutput("reload wr_ready", wr_ready, 0);
      end
      if (i == 3)
        load_req = 1'b0;
    end

    for (int i = 0; i < 7; i++)
      checkVector(map1Vecs[i]);

`ifdef TILEMAP_REMAIN_CNT_EN
    checkOutput("lc after map1", level_clear, 0);
    writeTile(4'd3, 4'd3, FREE, "lc w1");
    writeTile(4'd3, 4'd5, FREE, "lc w2");
    checkOutput("lc after w2", level_clear, 0);
    writeTile(4'd3, 4'd7, FREE, "lc w3");
    checkOutput("lc same cycle w3", level_clear, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("lc one after w3", level_clear, 1);
    writeTile(4'd3, 4'd3, BRKB, "lc restore");
    @(posedge clk);
    @(negedge clk);
    checkOutput("lc after restore", level_clear, 0);
`else
    checkOutput("lc tied low a", level_clear, 0);
    writeTile(4'd3, 4'd3, FREE, "lc w1");
    @(posedge clk);
    @(negedge clk);
    checkOutput("lc tied low b", level_clear, 0);
`endif

    // Reset at load row 4 of map 1: grid must come back FREE and map 0 must load.
    @(negedge clk);
    pixelX = 11'd5;
    pixelY = 11'd400;
    map_sel = 1'b1;
    load_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_req = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midload rst busy", load_busy, 1);
    checkOutput("midload rst rgb", RGBout, 8'hFF);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("rst-load type c%0d", i), tile_type, (i == 8) ? 1 : 0);
      checkOutput($sformatf("rst-load draw c%0d", i), tile_drawingRequest, (i == 8));
      checkOutput($sformatf("rst-load busy c%0d", i), load_busy, (i < 7));
    end
    checkVector('{name:"post-rst map0 11", x:70, y:70, draw:1, ttype:2, rgb:8'hE0, offx:6, offy:6});
    checkVector('{name:"post-rst map0 64", x:260, y:400, draw:0, ttype:0, rgb:8'hFF, offx:4, offy:16});
    checkVector('{name:"post-rst map0 23", x:200, y:140, draw:0, ttype:0, rgb:8'hFF, offx:8, offy:12});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
